// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Function : Single-outstanding RISC-V load/store unit with held bus
//            handshake, alignment fault and stallable writeback port.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req_rdy,
    output logic              lsu_req_ack,
    input  logic [3:0]        lsu_funct,
    input  logic [XLEN-1:0]   lsu_base,
    input  logic [XLEN-1:0]   lsu_offset,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic [4:0]        lsu_rsd,
    output logic [ADDR_W-1:0] data_bif_addr,
    output logic              data_bif_req,
    output logic              data_bif_rnw,
    output logic [XLEN/8-1:0] data_bif_wmask,
    output logic [XLEN-1:0]   data_bif_wdata,
    input  logic [XLEN-1:0]   data_bif_rdata,
    input  logic              data_bif_ack,
    output logic [XLEN-1:0]   wb_rf_data,
    output logic [4:0]        wb_rf_rsd,
    output logic              wb_rf_write,
    input  logic              wb_rf_ack,
    output logic              lsu_fault,
    output logic [XLEN-1:0]   lsu_fault_addr
);

    localparam int c_NBYTES = XLEN / 8;
    localparam int c_LANE_W = $clog2(c_NBYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  w_accept;
    logic [XLEN-1:0]       w_ea;
    logic [1:0]            w_size;
    logic [c_LANE_W-1:0]   w_lane;
    logic                  w_fault;
    logic [c_NBYTES-1:0]   w_size_mask;
    logic [c_NBYTES-1:0]   w_wmask;
    logic [XLEN-1:0]       w_wdata_rep;
    logic [ADDR_W-1:0]     w_bus_addr;

    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [c_LANE_W-1:0]   r_lane;
    logic [4:0]            r_rsd;

    logic [XLEN-1:0]       w_shift;
    logic [XLEN-1:0]       w_keep;
    logic                  w_sign;
    logic [XLEN-1:0]       w_load_ext;

    assign lsu_req_ack = (r_state == S_IDLE) & ~rst;
    assign w_accept    = lsu_req_rdy & lsu_req_ack;
    assign w_ea        = lsu_base + lsu_offset;
    assign w_size      = lsu_funct[1:0];
    assign w_lane      = w_ea[c_LANE_W-1:0];
    assign w_bus_addr  = {w_ea[ADDR_W-1:c_LANE_W], {c_LANE_W{1'b0}}};

    // Doubleword is illegal on a 32-bit datapath regardless of alignment.
    always_comb begin
        w_fault     = 1'b0;
        w_size_mask = '0;
        case (w_size)
            2'd0: begin
                w_fault     = 1'b0;
                w_size_mask = c_NBYTES'(8'h01);
            end
            2'd1: begin
                w_fault     = w_ea[0];
                w_size_mask = c_NBYTES'(8'h03);
            end
            2'd2: begin
                w_fault     = |w_ea[1:0];
                w_size_mask = c_NBYTES'(8'h0F);
            end
            default: begin
                w_fault     = (XLEN == 32) | (|w_ea[2:0]);
                w_size_mask = c_NBYTES'(8'hFF);
            end
        endcase
    end

    assign w_wmask = lsu_funct[3] ? (w_size_mask << w_lane) : '0;

    always_comb begin
        w_wdata_rep = '0;
        for (int i = 0; i < c_NBYTES; i++) begin
            case (w_size)
                2'd0:    w_wdata_rep[8*i +: 8] = lsu_wdata[7:0];
                2'd1:    w_wdata_rep[8*i +: 8] = lsu_wdata[8*(i%2) +: 8];
                2'd2:    w_wdata_rep[8*i +: 8] = lsu_wdata[8*(i%4) +: 8];
                default: w_wdata_rep[8*i +: 8] = lsu_wdata[8*(i%8) +: 8];
            endcase
        end
    end

    // Load data: shift the addressed lane down, then mask and extend.
    assign w_shift = data_bif_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_keep = '1;
        w_sign = 1'b0;
        case (r_size)
            2'd0: begin
                w_keep = XLEN'(8'hFF);
                w_sign = w_shift[7];
            end
            2'd1: begin
                w_keep = XLEN'(16'hFFFF);
                w_sign = w_shift[15];
            end
            2'd2: begin
                w_keep = XLEN'(32'hFFFF_FFFF);
                w_sign = w_shift[31];
            end
            default: begin
                w_keep = '1;
                w_sign = w_shift[XLEN-1];
            end
        endcase
    end

    assign w_load_ext = (w_shift & w_keep) | ((w_sign & ~r_unsigned) ? ~w_keep : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_fault) begin
                    w_state_nxt = S_BUS;
                end
            end
            S_BUS: begin
                if (data_bif_ack) begin
                    w_state_nxt = (data_bif_rnw && (r_rsd != 5'd0)) ? S_WB : S_IDLE;
                end
            end
            S_WB: begin
                if (wb_rf_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_bif_req   <= 1'b0;
            data_bif_rnw   <= 1'b0;
            data_bif_addr  <= '0;
            data_bif_wmask <= '0;
            data_bif_wdata <= '0;
            wb_rf_write    <= 1'b0;
            wb_rf_data     <= '0;
            wb_rf_rsd      <= 5'd0;
            lsu_fault      <= 1'b0;
            lsu_fault_addr <= '0;
            r_size         <= 2'd0;
            r_unsigned     <= 1'b0;
            r_lane         <= '0;
            r_rsd          <= 5'd0;
        end else begin
            lsu_fault <= 1'b0;
            if (w_accept) begin
                if (w_fault) begin
                    lsu_fault      <= 1'b1;
                    lsu_fault_addr <= w_ea;
                end else begin
                    data_bif_req   <= 1'b1;
                    data_bif_rnw   <= ~lsu_funct[3];
                    data_bif_addr  <= w_bus_addr;
                    data_bif_wmask <= w_wmask;
                    data_bif_wdata <= w_wdata_rep;
                    r_size         <= w_size;
                    r_unsigned     <= lsu_funct[2];
                    r_lane         <= w_lane;
                    r_rsd          <= lsu_rsd;
                end
            end
            if ((r_state == S_BUS) && data_bif_ack) begin
                data_bif_req <= 1'b0;
                if (data_bif_rnw && (r_rsd != 5'd0)) begin
                    wb_rf_write <= 1'b1;
                    wb_rf_data  <= w_load_ext;
                    wb_rf_rsd   <= r_rsd;
                end
            end
            if ((r_state == S_WB) && wb_rf_ack) begin
                wb_rf_write <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Function : Scoreboard bench for riscv_lsu, XLEN=32 and XLEN=64 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  rdy, bif_ack, wb_ack;
    logic [3:0]  funct;
    logic [63:0] base, offset, wdata, rdata;
    logic [4:0]  rsd;

    logic        a_req_ack, a_req, a_rnw, a_wb_write, a_fault;
    logic [31:0] a_addr, a_wdata, a_wb_data, a_fault_addr;
    logic [3:0]  a_wmask;
    logic [4:0]  a_wb_rsd;

    logic        b_req_ack, b_req, b_rnw, b_wb_write, b_fault;
    logic [63:0] b_addr, b_wdata, b_wb_data, b_fault_addr;
    logic [7:0]  b_wmask;
    logic [4:0]  b_wb_rsd;

    riscv_lsu #(.XLEN(32), .ADDR_W(32)) u_lsu32 (
        .clk(clk), .rst(rst),
        .lsu_req_rdy(rdy[0]), .lsu_req_ack(a_req_ack), .lsu_funct(funct),
        .lsu_base(base[31:0]), .lsu_offset(offset[31:0]), .lsu_wdata(wdata[31:0]),
        .lsu_rsd(rsd),
        .data_bif_addr(a_addr), .data_bif_req(a_req), .data_bif_rnw(a_rnw),
        .data_bif_wmask(a_wmask), .data_bif_wdata(a_wdata),
        .data_bif_rdata(rdata[31:0]), .data_bif_ack(bif_ack[0]),
        .wb_rf_data(a_wb_data), .wb_rf_rsd(a_wb_rsd), .wb_rf_write(a_wb_write),
        .wb_rf_ack(wb_ack[0]),
        .lsu_fault(a_fault), .lsu_fault_addr(a_fault_addr)
    );

    riscv_lsu #(.XLEN(64), .ADDR_W(64)) u_lsu64 (
        .clk(clk), .rst(rst),
        .lsu_req_rdy(rdy[1]), .lsu_req_ack(b_req_ack), .lsu_funct(funct),
        .lsu_base(base), .lsu_offset(offset), .lsu_wdata(wdata),
        .lsu_rsd(rsd),
        .data_bif_addr(b_addr), .data_bif_req(b_req), .data_bif_rnw(b_rnw),
        .data_bif_wmask(b_wmask), .data_bif_wdata(b_wdata),
        .data_bif_rdata(rdata), .data_bif_ack(bif_ack[1]),
        .wb_rf_data(b_wb_data), .wb_rf_rsd(b_wb_rsd), .wb_rf_write(b_wb_write),
        .wb_rf_ack(wb_ack[1]),
        .lsu_fault(b_fault), .lsu_fault_addr(b_fault_addr)
    );

    // Uniform view of both instances, indexed by DUT id (0 = 32-bit, 1 = 64-bit).
    logic [1:0]  m_req_ack, m_req, m_rnw, m_wb_write, m_fault;
    logic [63:0] m_addr [2];
    logic [63:0] m_wdata [2];
    logic [63:0] m_wb_data [2];
    logic [63:0] m_fault_addr [2];
    logic [7:0]  m_wmask [2];
    logic [4:0]  m_wb_rsd [2];

    always_comb begin
        m_req_ack       = {b_req_ack, a_req_ack};
        m_req           = {b_req, a_req};
        m_rnw           = {b_rnw, a_rnw};
        m_wb_write      = {b_wb_write, a_wb_write};
        m_fault         = {b_fault, a_fault};
        m_addr[0]       = {32'd0, a_addr};
        m_addr[1]       = b_addr;
        m_wdata[0]      = {32'd0, a_wdata};
        m_wdata[1]      = b_wdata;
        m_wb_data[0]    = {32'd0, a_wb_data};
        m_wb_data[1]    = b_wb_data;
        m_fault_addr[0] = {32'd0, a_fault_addr};
        m_fault_addr[1] = b_fault_addr;
        m_wmask[0]      = {4'd0, a_wmask};
        m_wmask[1]      = b_wmask;
        m_wb_rsd[0]     = a_wb_rsd;
        m_wb_rsd[1]     = b_wb_rsd;
    end

    typedef struct {
        int          d;
        logic [63:0] addr;
        logic        rnw;
        logic [7:0]  wmask;
        logic [63:0] wdata;
    } bus_t;

    typedef struct {
        int          d;
        logic [63:0] data;
        logic [4:0]  rsd;
    } wb_t;

    typedef struct {
        int          d;
        logic [63:0] addr;
    } flt_t;

    bus_t busq[$];
    wb_t  wbq[$];
    flt_t fq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int wb_cycles  = 0;
    int bus_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_bus(input int d, input logic [63:0] addr, input logic rnw,
                           input logic [7:0] wmask, input logic [63:0] wd);
        busq.push_back('{d: d, addr: addr, rnw: rnw, wmask: wmask, wdata: wd});
    endtask

    task automatic exp_wb(input int d, input logic [63:0] data, input logic [4:0] r);
        wbq.push_back('{d: d, data: data, rsd: r});
    endtask

    task automatic exp_flt(input int d, input logic [63:0] addr);
        fq.push_back('{d: d, addr: addr});
    endtask

    // Monitor: compares every cycle an output is presented, so held values are checked too.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (m_req[d]) begin
                    bus_cycles++;
                    if (busq.size() == 0) begin
                        chk("bus_unexpected", 64'(m_req[d]), 64'd0);
                    end else begin
                        chk("bus_dut", 64'(d), 64'(busq[0].d));
                        chk("bus_addr", m_addr[d], busq[0].addr);
                        chk("bus_rnw", 64'(m_rnw[d]), 64'(busq[0].rnw));
                        chk("bus_wmask", 64'(m_wmask[d]), 64'(busq[0].wmask));
                        if (!busq[0].rnw) chk("bus_wdata", m_wdata[d], busq[0].wdata);
                        if (bif_ack[d]) void'(busq.pop_front());
                    end
                end
                if (m_wb_write[d]) begin
                    wb_cycles++;
                    if (wbq.size() == 0) begin
                        chk("wb_unexpected", 64'(m_wb_write[d]), 64'd0);
                    end else begin
                        chk("wb_dut", 64'(d), 64'(wbq[0].d));
                        chk("wb_data", m_wb_data[d], wbq[0].data);
                        chk("wb_rsd", 64'(m_wb_rsd[d]), 64'(wbq[0].rsd));
                        if (wb_ack[d]) void'(wbq.pop_front());
                    end
                end
                if (m_fault[d]) begin
                    if (fq.size() == 0) begin
                        chk("fault_unexpected", 64'(m_fault[d]), 64'd0);
                    end else begin
                        chk("fault_dut", 64'(d), 64'(fq[0].d));
                        chk("fault_addr", m_fault_addr[d], fq[0].addr);
                        void'(fq.pop_front());
                    end
                end
            end
        end
    end

    task automatic op(input int d, input logic [3:0] f, input logic [63:0] b, input logic [63:0] o,
                      input logic [63:0] wd, input logic [4:0] rd_i, input logic [63:0] rdat,
                      input int bus_wait, input int wb_wait, input bit has_bus, input bit has_wb);
        int t = 0;
        while (!m_req_ack[d] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_ack_ready", 64'(m_req_ack[d]), 64'd1);
        funct = f; base = b; offset = o; wdata = wd; rsd = rd_i; rdy[d] = 1'b1;
        @(posedge clk); #1;
        rdy[d] = 1'b0;
        if (has_bus) begin
            chk("bus_req_n1", 64'(m_req[d]), 64'd1);
            repeat (bus_wait) begin @(posedge clk); #1; end
            rdata = rdat; bif_ack[d] = 1'b1;
            @(posedge clk); #1;
            bif_ack[d] = 1'b0;
            if (has_wb) begin
                chk("wb_write_start", 64'(m_wb_write[d]), 64'd1);
                repeat (wb_wait) begin @(posedge clk); #1; end
                wb_ack[d] = 1'b1;
                @(posedge clk); #1;
                wb_ack[d] = 1'b0;
            end else begin
                chk("no_wb_write", 64'(m_wb_write[d]), 64'd0);
            end
            chk("idle_again", 64'(m_req_ack[d]), 64'd1);
        end else begin
            chk("fault_ack_n1", 64'(m_req_ack[d]), 64'd1);
            repeat (3) begin
                chk("fault_no_req", 64'(m_req[d]), 64'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int t;
        rdy = '0; bif_ack = '0; wb_ack = '0;
        funct = '0; base = '0; offset = '0; wdata = '0; rdata = '0; rsd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ack32", 64'(a_req_ack), 64'd0);
        chk("rst_req_ack64", 64'(b_req_ack), 64'd0);
        chk("rst_req", 64'({a_req, b_req}), 64'd0);
        chk("rst_wb_write", 64'({a_wb_write, b_wb_write}), 64'd0);
        chk("rst_fault", 64'({a_fault, b_fault}), 64'd0);
        chk("rst_addr", m_addr[0] | m_addr[1], 64'd0);
        chk("rst_wdata", m_wdata[0] | m_wdata[1], 64'd0);
        chk("rst_wmask", 64'(a_wmask) | 64'(b_wmask), 64'd0);
        chk("rst_wb_data", m_wb_data[0] | m_wb_data[1], 64'd0);
        chk("rst_fault_addr", m_fault_addr[0] | m_fault_addr[1], 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ack", 64'(m_req_ack), 64'd3);

        // LB: ea 0x1003, lane 3 -> 0x80 sign-extended
        exp_bus(0, 64'h1000, 1'b1, 8'h0, 64'h0);
        exp_wb(0, 64'hFFFF_FF80, 5'd1);
        op(0, 4'h0, 64'h1000, 64'h3, 64'h0, 5'd1, 64'h80FF_1234, 0, 0, 1, 1);

        // LHU: ea 0x2002, lane 2 -> 0xBEEF zero-extended
        exp_bus(0, 64'h2000, 1'b1, 8'h0, 64'h0);
        exp_wb(0, 64'h0000_BEEF, 5'd2);
        op(0, 4'h5, 64'h2000, 64'h2, 64'h0, 5'd2, 64'hBEEF_0000, 1, 0, 1, 1);

        // SB: ea 0x3003 with 3 wait states, outputs held 4 cycles
        exp_bus(0, 64'h3000, 1'b0, 8'h8, 64'hABAB_ABAB);
        bus_cycles = 0;
        op(0, 4'h8, 64'h3000, 64'h3, 64'h1234_56AB, 5'd0, 64'h0, 3, 0, 1, 0);
        chk("sb_req_cycles", 64'(bus_cycles), 64'd4);

        // SH: ea 0x7002 -> upper halfword lanes
        exp_bus(0, 64'h7000, 1'b0, 8'hC, 64'hBEEF_BEEF);
        op(0, 4'h9, 64'h7000, 64'h2, 64'hA5A5_BEEF, 5'd0, 64'h0, 0, 0, 1, 0);

        // LH signed: upper half 0x8001 -> 0xFFFF8001
        exp_bus(0, 64'h7000, 1'b1, 8'h0, 64'h0);
        exp_wb(0, 64'hFFFF_8001, 5'd9);
        op(0, 4'h1, 64'h7000, 64'h2, 64'h0, 5'd9, 64'h8001_0000, 0, 0, 1, 1);

        // LB to x0: bus read but no writeback
        exp_bus(0, 64'h1000, 1'b1, 8'h0, 64'h0);
        op(0, 4'h0, 64'h1000, 64'h1, 64'h0, 5'd0, 64'hFFFF_FFFF, 0, 0, 1, 0);

        // LW misaligned at 0x4002
        exp_flt(0, 64'h4002);
        op(0, 4'h2, 64'h4000, 64'h2, 64'h0, 5'd1, 64'h0, 0, 0, 0, 0);

        // LD on a 32-bit datapath is an illegal size
        exp_flt(0, 64'h8);
        op(0, 4'h3, 64'h0, 64'h8, 64'h0, 5'd1, 64'h0, 0, 0, 0, 0);

        // LW to x7 with writeback stalled 2 cycles; ea wraps 0x5100+0xFFFFFF00
        exp_bus(0, 64'h5000, 1'b1, 8'h0, 64'h0);
        exp_wb(0, 64'hCAFE_F00D, 5'd7);
        wb_cycles = 0;
        op(0, 4'h2, 64'h5100, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, 5'd7, 64'hCAFE_F00D, 1, 2, 1, 1);
        chk("lw_wb_cycles", 64'(wb_cycles), 64'd3);

        // SW interrupted by reset mid-BUS
        exp_bus(0, 64'h6004, 1'b0, 8'hF, 64'h1122_3344);
        t = 0;
        while (!a_req_ack && t < 50) begin @(posedge clk); #1; t++; end
        funct = 4'hA; base = 64'h6000; offset = 64'h4; wdata = 64'h1122_3344; rsd = 5'd0;
        rdy[0] = 1'b1;
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        chk("sw_req_up", 64'(a_req), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", 64'(a_req), 64'd0);
        chk("arst_addr", 64'(a_addr), 64'd0);
        chk("arst_wmask", 64'(a_wmask), 64'd0);
        chk("arst_wdata", 64'(a_wdata), 64'd0);
        chk("arst_rnw", 64'(a_rnw), 64'd0);
        chk("arst_wb", 64'({a_wb_write, a_wb_rsd}) | 64'(a_wb_data), 64'd0);
        chk("arst_fault", 64'(a_fault) | 64'(a_fault_addr), 64'd0);
        chk("arst_req_ack", 64'(a_req_ack), 64'd0);
        busq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_arst_quiet", 64'({a_req, a_wb_write}), 64'd0);
        end

        // XLEN=64: LD at 0x8
        exp_bus(1, 64'h8, 1'b1, 8'h0, 64'h0);
        exp_wb(1, 64'hDEAD_BEEF_0123_4567, 5'd4);
        op(1, 4'h3, 64'h0, 64'h8, 64'h0, 5'd4, 64'hDEAD_BEEF_0123_4567, 0, 0, 1, 1);

        // XLEN=64: LWU at 0x4 -> upper word lane
        exp_bus(1, 64'h0, 1'b1, 8'h0, 64'h0);
        exp_wb(1, 64'h0000_0000_8000_0001, 5'd5);
        op(1, 4'h6, 64'h0, 64'h4, 64'h0, 5'd5, 64'h8000_0001_0000_0000, 0, 0, 1, 1);

        // XLEN=64: SW at 0xC
        exp_bus(1, 64'h8, 1'b0, 8'hF0, 64'hCAFE_BABE_CAFE_BABE);
        op(1, 4'hA, 64'h8, 64'h4, 64'h0000_0000_CAFE_BABE, 5'd0, 64'h0, 1, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("busq_drained", 64'(busq.size()), 64'd0);
        chk("wbq_drained", 64'(wbq.size()), 64'd0);
        chk("fq_drained", 64'(fq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit for the RISC-V execute stage, successor to the fixed 32-bit load/store path in `riscv_ex_pipe`. It accepts one memory operation at a time from decode/execute and computes the effective address. It checks natural alignment and drives the data bus interface with a held request/ack handshake. Load results are extracted, sign- or zero-extended and returned to the register file over a stallable writeback port. The unit supports XLEN of 32 or 64, bus wait states and a precise misalignment fault.

## Interface
Parameters:
- XLEN, 32: datapath and bus data width; legal values 32 or 64.
- ADDR_W, 32: bus address width; must be ≤ XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- lsu_req_rdy  in  1  request valid.
- lsu_req_ack  out  1  request accepted this cycle; a transfer occurs when rdy & ack.
- lsu_funct  in  4  bit3 = store; bit2 = unsigned (loads only); bits[1:0] = size (0 B, 1 H, 2 W, 3 D).
- lsu_base  in  XLEN  base operand.
- lsu_offset  in  XLEN  offset operand.
- lsu_wdata  in  XLEN  store data, right-aligned.
- lsu_rsd  in  5  load destination register.
- data_bif_addr  out  ADDR_W  bus-word-aligned address.
- data_bif_req  out  1  bus request.
- data_bif_rnw  out  1  1 = read, 0 = write.
- data_bif_wmask  out  XLEN/8  byte write enable.
- data_bif_wdata  out  XLEN  lane-replicated write data.
- data_bif_rdata  in  XLEN  read data, valid with ack.
- data_bif_ack  in  1  bus completion.
- wb_rf_data  out  XLEN  extended load result.
- wb_rf_rsd  out  5  destination register.
- wb_rf_write  out  1  writeback valid.
- wb_rf_ack  in  1  register file accepted writeback.
- lsu_fault  out  1  one-cycle misalignment or illegal-size pulse.
- lsu_fault_addr  out  XLEN  faulting effective address.

## Operation
- The FSM has three states: IDLE, BUS, WB.
- lsu_req_ack = (state == IDLE) & ~rst. It does not depend combinationally on lsu_req_rdy.
- The request is registered on accept.
- Effective address: ea = lsu_base + lsu_offset, modulo 2^XLEN, with carry dropped.
- Size bytes sb = 1 << size.
- Fault conditions:
  - ea[log2(sb)-1:0] != 0.
  - size == D when XLEN == 32.
- On a fault, the FSM stays in IDLE:
  - lsu_fault pulses in the next cycle, with lsu_fault_addr = ea.
  - No bus access and no writeback occur.
- If there is no fault, the FSM moves IDLE→BUS. Bus signals are all registered:
  - data_bif_addr = ea[ADDR_W-1:0] with its low log2(XLEN/8) bits cleared.
  - data_bif_rnw = ~bit3.
  - data_bif_wmask = ((1<<sb)-1) << lane, where lane = ea mod (XLEN/8). The mask is all zero for reads.
  - data_bif_wdata = lsu_wdata[8·sb-1:0] replicated across the full XLEN.
- In BUS, data_bif_req and all bus outputs are held stable until data_bif_ack is sampled high.
  - Store: BUS→IDLE on ack.
  - Load: capture (rdata >> 8·lane), keep the low 8·sb bits, then sign-extend (unsigned = 0) or zero-extend (unsigned = 1) to XLEN.
    - rsd != 0: BUS→WB.
    - rsd == 0: BUS→IDLE, with no writeback.
- In WB, wb_rf_write is high with data and rsd held until wb_rf_ack is sampled high, then WB→IDLE.
- Only one operation is outstanding at a time. Bus ack outside BUS is ignored. wb_rf_ack outside WB is ignored.

## Timing
- Reset values:
  - state IDLE.
  - data_bif_req, data_bif_rnw, data_bif_wmask, data_bif_addr, data_bif_wdata all 0.
  - wb_rf_write, wb_rf_data, wb_rf_rsd all 0.
  - lsu_fault 0, lsu_fault_addr 0.
  - lsu_req_ack 0 while rst is high.
- Cycle timeline: accept in cycle N; data_bif_req high in N+1. With ack in N+k:
  - Store: lsu_req_ack high again in N+k+1.
  - Load: wb_rf_write high in N+k+1.
- Zero-wait bus (ack in N+1):
  - Back-to-back stores sustain 1 operation per 2 cycles.
  - Loads with an immediate wb_rf_ack sustain 1 operation per 3 cycles.
- Fault: pulse in N+1. lsu_req_ack stays high, so a new request can be accepted in N+1.
- Reset asserted mid-BUS or mid-WB drops req and write asynchronously. The operation is abandoned and no writeback occurs after reset release.

## Test plan
- XLEN=32, LB (funct 0x0):
  - Stimulus: base 0x1000, offset 0x3, rdata 0x80FF_1234.
  - Required: bus addr 0x1000, rnw 1; wb_rf_data 0xFFFF_FF80.
- LHU (funct 0x5):
  - Stimulus: ea 0x2002, rdata 0xBEEF_0000.
  - Required: wb_rf_data 0x0000_BEEF.
- SB (funct 0x8):
  - Stimulus: ea 0x3003, wdata 0x1234_56AB, ack delayed 3 cycles.
  - Required: wmask 0x8 and wdata 0xABAB_ABAB, both held stable for 4 cycles; no wb_rf_write.
- LW misaligned:
  - Stimulus: ea 0x4002.
  - Required: lsu_fault 1 for one cycle with fault_addr 0x4002; data_bif_req never rises.
- LW to rsd 7 with wb_rf_ack held low 2 cycles, then rst asserted during a following SW:
  - Required: wb_rf_write held 3 cycles with data stable; on reset, req drops immediately and all outputs are 0.
- XLEN=64, LD and LWU:
  - Stimulus: ea 0x8 with rdata 0xDEAD_BEEF_0123_4567; then LWU (funct 0x6) at ea 0x4 with rdata 0x8000_0001_0000_0000.
  - Required: LD wb 0xDEAD_BEEF_0123_4567; LWU wb 0x0000_0000_8000_0001.
